// File: rtl/shift_add_serial_multiplier.sv
// Unsigned sequential shift-and-add multiplier.
// Each RUN cycle consumes one multiplier bit, LSB first.
// Result is registered and changes only when a product completes or on reset.
module shift_add_serial_multiplier #(
    parameter int WL = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            LOAD,
    input  logic [2*WL-1:0] Ain,
    input  logic [2*WL-1:0] Bin,
    output logic [2*WL-1:0] Result
);
    localparam int CW = $clog2(WL + 1);
    localparam logic [CW-1:0] LAST = CW'(WL - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [2*WL-1:0] mcand;
    logic [2*WL-1:0] acc;
    logic [WL-1:0]   mplier;
    logic [CW-1:0]   cnt;

    // The upper halves of the operand buses are intentionally ignored.
    logic unused_upper;
    assign unused_upper = ^{Ain[2*WL-1:WL], Bin[2*WL-1:WL]};

    // State register; reset returns to IDLE and aborts any multiplication.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: fixed WL iterations, no early exit on zero multiplier.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (LOAD) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture operands, shift-and-accumulate, publish product.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            Result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (LOAD) begin
                        mcand  <= {{WL{1'b0}}, Ain[WL-1:0]};
                        mplier <= Bin[WL-1:0];
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    // 2*WL-bit sum cannot overflow: max product is (2^WL-1)^2.
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                DONE: Result <= acc;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_serial_multiplier.sv
// Scoreboard bench: stimulus pushes expected Result values tagged with the
// clock edge at which they must appear; the monitor checks Result after every
// edge, either against a due entry or against the previously held value.
module tb_shift_add_serial_multiplier;
    localparam int WL = 4;
    localparam int W  = 2 * WL;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         LOAD = 1'b0;
    logic [W-1:0] Ain = '0;
    logic [W-1:0] Bin = '0;
    logic [W-1:0] Result;

    logic         load8 = 1'b0;
    logic [15:0]  ain8 = '0;
    logic [15:0]  bin8 = '0;
    logic [15:0]  result8;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [W-1:0] val;
        int           due;
    } exp_t;
    exp_t q[$];

    shift_add_serial_multiplier #(.WL(WL)) dut (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .Ain(Ain), .Bin(Bin), .Result(Result)
    );

    shift_add_serial_multiplier #(.WL(8)) dut8 (
        .CLK(CLK), .RST(RST), .LOAD(load8), .Ain(ain8), .Bin(bin8), .Result(result8)
    );

    always #5 CLK = ~CLK;

    // Edge counter: after edge n, cyc == n.
    always @(posedge CLK) cyc <= cyc + 1;

    // Reference: plain product of the low WL bits of each bus.
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] am, bm;
        am = a & W'((1 << WL) - 1);
        bm = b & W'((1 << WL) - 1);
        return am * bm;
    endfunction

    // Monitor
    initial begin
        logic [W-1:0] held;
        bit started;
        started = 0;
        held = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0 && q[0].due == cyc) begin
                n_checks++;
                if (Result !== q[0].val) begin
                    n_fail++;
                    $display("FAIL result_due edge=%0d got %h expected %h", cyc, Result, q[0].val);
                end
                held = q[0].val;
                started = 1;
                void'(q.pop_front());
            end else if (started) begin
                n_checks++;
                if (Result !== held) begin
                    n_fail++;
                    $display("FAIL result_hold edge=%0d got %h expected %h", cyc, Result, held);
                end
            end
        end
    end

    task automatic reset_cycle(input logic ld, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge CLK);
        RST = 1'b1; LOAD = ld; Ain = a; Bin = b;
        q.delete();
        q.push_back('{val: '0, due: cyc + 1});
    endtask

    // One multiplication, then junk on the inputs during RUN, idle on DONE,
    // so the next call's LOAD lands on the first IDLE edge.
    task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge CLK);
        RST = 1'b0; LOAD = 1'b1; Ain = a; Bin = b;
        q.push_back('{val: ref_mul(a, b), due: cyc + WL + 2});
        for (int i = 0; i < WL + 1; i++) begin
            @(negedge CLK);
            Ain  = W'($urandom);
            Bin  = W'($urandom);
            LOAD = (i < WL) ? 1'($urandom) : 1'b0;
        end
    endtask

    // Stimulus
    initial begin
        int k;
        bit hit;
        for (int i = 0; i < 4; i++) reset_cycle(1'(i), 8'h05, 8'h0B);

        mul(8'h05, 8'h0B);
        mul(8'h0F, 8'h0F);
        mul(8'h0E, 8'h07);
        mul(8'h0A, 8'h05);
        mul(8'h08, 8'h08);
        mul(8'h00, 8'h0B);
        mul(8'hF5, 8'hAB);

        // Abort on the second RUN edge; the pending product must never land.
        @(negedge CLK);
        LOAD = 1'b1; Ain = 8'h0F; Bin = 8'h0F;
        q.push_back('{val: 8'hE1, due: cyc + WL + 2});
        @(negedge CLK);
        LOAD = 1'b0;
        reset_cycle(1'b1, 8'h0F, 8'h0F);
        mul(8'h03, 8'h03);

        for (int i = 0; i < 20; i++) mul(W'($urandom), W'($urandom));

        @(negedge CLK);
        LOAD = 1'b0;
        repeat (3) @(negedge CLK);

        // Wide instance: 0xFF * 0xFF with 9-edge latency.
        load8 = 1'b1; ain8 = 16'h00FF; bin8 = 16'h00FF;
        k = cyc + 1;
        @(negedge CLK);
        load8 = 1'b0; ain8 = 16'h1234; bin8 = 16'h5678;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge CLK);
            #2;
            if (cyc == k + 8) begin
                n_checks++;
                if (result8 !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL wl8_before got %h expected %h", result8, 16'h0000);
                end
            end
            if (cyc == k + 9) begin
                hit = 1;
                n_checks++;
                if (result8 !== 16'hFE01) begin
                    n_fail++;
                    $display("FAIL wl8_product got %h expected %h", result8, 16'hFE01);
                end
            end
        end
        if (!hit) begin
            n_fail++;
            $display("FAIL wl8_timeout got none expected %h", 16'hFE01);
        end

        repeat (3) @(negedge CLK);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d expected %0d", q.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
